ipif_req_arbiter: RTL



---
 rtl/ipif_req_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ipif_req_arbiter.sv
`timescale 1ns/1ps
// ipif_req_arbiter
// Shares one IPIF register slave between NUM_REQ requesters. Round-robin grant,
// one single-beat transaction in flight, one-cycle CS strobe, ack wait with timeout.
//
// Ports
//   Bus2IP_Clk / Bus2IP_Resetn       clock, async active-low reset
//   req_valid/rnw/addr/data/be       packed per-requester requests (slice i = requester i)
//   req_ack                          one-hot pulse when a request is captured
//   rsp_valid/rsp_data/rsp_error     one-hot completion pulse with read data / error
//   busy                             grant through rsp_valid inclusive
//   Bus2IP_CS/RNW/Addr/Data/BE       to slave
//   IP2Bus_Data/RdAck/WrAck/Error    from slave
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | arbitrate; on a request capture winner, pulse req_ack, set CS
// ISSUE  | CS high this cycle; clear timeout counter
// WAIT   | wait for matching ack or timeout; load response
// RESP   | rsp_valid pulse; drop busy
module ipif_req_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REQ            = 2,
    parameter int TIMEOUT_CYCLES     = 64
) (
    input  logic                                        Bus2IP_Clk,
    input  logic                                        Bus2IP_Resetn,
    input  logic [NUM_REQ-1:0]                          req_valid,
    input  logic [NUM_REQ-1:0]                          req_rnw,
    input  logic [NUM_REQ*C_S_AXI_ADDR_WIDTH-1:0]       req_addr,
    input  logic [NUM_REQ*C_S_AXI_DATA_WIDTH-1:0]       req_data,
    input  logic [NUM_REQ*(C_S_AXI_DATA_WIDTH/8)-1:0]   req_be,
    output logic [NUM_REQ-1:0]                          req_ack,
    output logic [NUM_REQ-1:0]                          rsp_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]               rsp_data,
    output logic                                        rsp_error,
    output logic                                        busy,
    output logic                                        Bus2IP_CS,
    output logic                                        Bus2IP_RNW,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]               Bus2IP_Addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]               Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]             Bus2IP_BE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]               IP2Bus_Data,
    input  logic                                        IP2Bus_RdAck,
    input  logic                                        IP2Bus_WrAck,
    input  logic                                        IP2Bus_Error
);

    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int BW  = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0] RR_RESET = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [IDW-1:0]      gnt_q, gnt_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]       rsp_data_q, rsp_data_d;
    logic                rsp_error_q, rsp_error_d;
    logic                busy_q, busy_d;
    logic                cs_q, cs_d;
    logic                rnw_q, rnw_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       data_q, data_d;
    logic [BW-1:0]       be_q, be_d;

    logic                found;
    logic [IDW-1:0]      win_idx;
    int                  best_dist;
    logic                ack_match;

    // Rank each requester by its distance from the slot after the last winner;
    // the previous winner therefore ranks last.
    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        best_dist = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j] &&
                (((j + 2*NUM_REQ - int'(rr_q) - 1) % NUM_REQ) < best_dist)) begin
                best_dist = (j + 2*NUM_REQ - int'(rr_q) - 1) % NUM_REQ;
                win_idx   = IDW'(j);
                found     = 1'b1;
            end
        end
    end

    // Only the ack type matching the captured direction can complete the transfer.
    assign ack_match = rnw_q ? IP2Bus_RdAck : IP2Bus_WrAck;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        busy_d      = busy_q;
        cs_d        = 1'b0;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (IDW'(i) == win_idx) begin
                            req_ack_d[i] = 1'b1;
                            rnw_d        = req_rnw[i];
                            addr_d       = req_addr[i*AW +: AW];
                            data_d       = req_data[i*DW +: DW];
                            be_d         = req_be[i*BW +: BW];
                        end
                    end
                    rr_d    = win_idx;
                    gnt_d   = win_idx;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A matching ack on the last counted cycle takes precedence over timeout.
                if (ack_match || (cnt_q == CNT_LAST)) begin
                    if (ack_match) begin
                        rsp_data_d  = rnw_q ? IP2Bus_Data : '0;
                        rsp_error_d = IP2Bus_Error;
                    end else begin
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b1;
                    end
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (IDW'(i) == gnt_q) begin
                            rsp_valid_d[i] = 1'b1;
                        end
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q     <= S_IDLE;
            rr_q        <= RR_RESET;
            gnt_q       <= '0;
            cnt_q       <= '0;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            busy_q      <= 1'b0;
            cs_q        <= 1'b0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            busy_q      <= busy_d;
            cs_q        <= cs_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign busy        = busy_q;
    assign Bus2IP_CS   = cs_q;
    assign Bus2IP_RNW  = rnw_q;
    assign Bus2IP_Addr = addr_q;
    assign Bus2IP_Data = data_q;
    assign Bus2IP_BE   = be_q;

endmodule
